local_port_arbiter: RTL and testbench

LOCAL_PORT_ARBITER -- requirements
Module: local_port_arbiter

---
 rtl/noc_arb_pkg.sv | 18 +
 rtl/local_port_arbiter_rr_pick.sv | 29 ++
 rtl/local_port_arbiter.sv | 110 +++++++++++
 tb/tb_local_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared definitions for the local-port arbiter: FSM encoding, default widths
// and the saturating grant-counter increment.
package noc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FWD     = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int GNT_CNT_W  = 16;

  function automatic logic [GNT_CNT_W-1:0] sat_inc(input logic [GNT_CNT_W-1:0] v);
    return (v == '1) ? v : v + GNT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/local_port_arbiter_rr_pick.sv
// Combinational round-robin pick: the first requester strictly after ptr,
// scanning upward with wrap-around.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int OWN_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [OWN_W-1:0] ptr,
  output logic [OWN_W-1:0] winner,
  output logic             valid
);

  logic [OWN_W-1:0] idx;

  // Scan from the farthest candidate down to ptr+1 so the nearest one wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = OWN_W'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/local_port_arbiter.sv
// Arbitrates NREQ injectors onto one router local port, one packet at a time.
// Defining ARB_GRANT_CNT_EN adds per-injector saturating grant counters.
//
//   state   | meaning
//   IDLE    | no owner; arbitrate when any request is up and the router is not full
//   FWD     | packet held on req_dn/pkt_dn until the router grants
//   RELEASE | grant delivered; wait for the owner to drop its request
module local_port_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OWN_W  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_in,
  input  logic [NREQ*DATA_W-1:0] pkt_in,
  output logic [NREQ-1:0]        gnt_out,
  output logic [NREQ-1:0]        full_out,
  output logic                   req_dn,
  output logic [DATA_W-1:0]      pkt_dn,
  input  logic                   gnt_dn,
  input  logic                   full_dn,
  output logic [OWN_W-1:0]       owner,
  output logic                   busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [NREQ*GNT_CNT_W-1:0] grant_cnt
`endif
);

  arb_state_e       state;
  logic [OWN_W-1:0] ptr;
  logic [OWN_W-1:0] winner;
  logic             win_valid;

  rr_pick #(
    .NREQ  (NREQ),
    .OWN_W (OWN_W)
  ) u_rr_pick (
    .req    (req_in),
    .ptr    (ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  // ptr resets to the last index so injector 0 is scanned first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      req_dn  <= 1'b0;
      gnt_out <= '0;
      pkt_dn  <= '0;
      owner   <= '0;
      ptr     <= OWN_W'(NREQ - 1);
    end else begin
      gnt_out <= '0;
      case (state)
        IDLE: begin
          if (win_valid && !full_dn) begin
            owner  <= winner;
            pkt_dn <= pkt_in[int'(winner)*DATA_W +: DATA_W];
            req_dn <= 1'b1;
            state  <= FWD;
          end
        end
        FWD: begin
          if (gnt_dn) begin
            req_dn         <= 1'b0;
            gnt_out[owner] <= 1'b1;
            ptr            <= owner;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          if (!req_in[owner]) state <= IDLE;
        end
        default: begin
          req_dn <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == FWD) || (state == RELEASE);

  always_comb begin
    full_out = '0;
    for (int i = 0; i < NREQ; i++) begin
      full_out[i] = full_dn | (busy & (owner != OWN_W'(i)));
    end
  end

`ifdef ARB_GRANT_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_out[i]) begin
          grant_cnt[i*GNT_CNT_W +: GNT_CNT_W] <= sat_inc(grant_cnt[i*GNT_CNT_W +: GNT_CNT_W]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_local_port_arbiter.sv
// Directed bench for local_port_arbiter with a transaction-level reference model
// checked every cycle; covers ARB_GRANT_CNT_EN when that macro is defined.
module tb_local_port_arbiter;
  import noc_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int OW   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_in = '0;
  logic [NREQ*DW-1:0] pkt_in = '0;
  logic [NREQ-1:0]   gnt_out;
  logic [NREQ-1:0]   full_out;
  logic              req_dn;
  logic [DW-1:0]     pkt_dn;
  logic              gnt_dn = 1'b0;
  logic              full_dn = 1'b0;
  logic [OW-1:0]     owner;
  logic              busy;
`ifdef ARB_GRANT_CNT_EN
  logic [NREQ*GNT_CNT_W-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  local_port_arbiter #(.NREQ(NREQ), .DATA_W(DW), .OWN_W(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .pkt_in    (pkt_in),
    .gnt_out   (gnt_out),
    .full_out  (full_out),
    .req_dn    (req_dn),
    .pkt_dn    (pkt_dn),
    .gnt_dn    (gnt_dn),
    .full_dn   (full_dn),
    .owner     (owner),
    .busy      (busy)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one packet in flight, then wait for the owner to let go.
  bit          m_in_flight, m_draining;
  int          m_owner, m_last;
  logic [DW-1:0] m_pkt;
  logic [NREQ-1:0] m_gnt;
  int          m_cnt[NREQ];

  function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_in_flight = 0;
      m_draining  = 0;
      m_owner     = 0;
      m_last      = NREQ - 1;
      m_pkt       = '0;
      m_gnt       = '0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else begin
      m_gnt = '0;
      if (m_in_flight) begin
        if (gnt_dn) begin
          m_in_flight    = 0;
          m_draining     = 1;
          m_gnt[m_owner] = 1'b1;
          m_last         = m_owner;
          if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
        end
      end else if (m_draining) begin
        if (!req_in[m_owner]) m_draining = 0;
      end else if (req_in != 0 && !full_dn) begin
        m_owner     = rr_next(req_in, m_last);
        m_pkt       = pkt_in[m_owner*DW +: DW];
        m_in_flight = 1;
      end
    end
  end

  always @(posedge clk) begin
    logic [NREQ-1:0] exp_full;
    bit m_busy;
    #1;
    m_busy = m_in_flight | m_draining;
    for (int i = 0; i < NREQ; i++) exp_full[i] = full_dn | (m_busy && (m_owner != i));
    chk("m_req_dn", req_dn, m_in_flight);
    chk("m_pkt_dn", pkt_dn, m_pkt);
    chk("m_gnt_out", gnt_out, m_gnt);
    chk("m_busy", busy, m_busy);
    if (m_busy) chk("m_owner", owner, m_owner);
    chk("m_full_out", full_out, exp_full);
    chk("gnt_onehot0", $onehot0(gnt_out), 1);
`ifdef ARB_GRANT_CNT_EN
    for (int i = 0; i < NREQ; i++) chk("m_grant_cnt", grant_cnt[i*GNT_CNT_W +: GNT_CNT_W], m_cnt[i]);
`endif
  end

  // Injector and router behaviour applied once per cycle at the falling edge.
  bit auto_router = 0;
  bit rearm = 0;
  int rdelay = 1;
  int rcnt = 0;
  bit dropped[NREQ];
  int hist[$];

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_out[i]) begin
        req_in[i]  = 1'b0;
        dropped[i] = 1;
        hist.push_back(i);
      end else if (dropped[i] && rearm) begin
        req_in[i]  = 1'b1;
        dropped[i] = 0;
      end
    end
    if (auto_router) begin
      if (req_dn && !gnt_dn) begin
        rcnt++;
        if (rcnt >= rdelay) gnt_dn = 1'b1;
      end else begin
        rcnt   = 0;
        gnt_dn = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    req_in      = '0;
    gnt_dn      = 1'b0;
    full_dn     = 1'b0;
    auto_router = 0;
    rearm       = 0;
    rcnt        = 0;
    for (int i = 0; i < NREQ; i++) dropped[i] = 0;
    hist.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && (busy || req_dn); n++) tick();
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clk);
    chk("rst_req_dn", req_dn, 0);
    chk("rst_gnt_out", gnt_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_pkt_dn", pkt_dn, 0);
    reset = 1'b1;

    // Single request, router grants two cycles after req_dn.
    pkt_in[0 +: DW] = 32'hA5A5_0001;
    auto_router = 1;
    rdelay = 2;
    req_in = 4'b0001;
    tick();
    chk("s1_latency", req_dn, 1);
    chk("s1_pkt_dn", pkt_dn, 32'hA5A5_0001);
    k = 0;
    while (k < 10 && gnt_out == 0) begin
      tick();
      k++;
    end
    chk("s1_gnt_out", gnt_out, 4'b0001);
    chk("s1_gnt_delay", k, 2);
    tick();
    chk("s1_gnt_pulse", gnt_out, 0);
    chk("s1_back_idle", busy, 0);

    // Fairness with all four re-requesting.
    do_reset();
    for (int i = 0; i < NREQ; i++) pkt_in[i*DW +: DW] = 32'hC0DE_0000 + i;
    auto_router = 1;
    rdelay = 1;
    rearm = 1;
    req_in = 4'b1111;
    for (int n = 0; n < 60 && hist.size() < 5; n++) tick();
    rearm = 0;
    chk("fair_count", hist.size(), 5);
    for (int j = 0; j < 5; j++)
      chk($sformatf("fair_owner%0d", j), (j < hist.size()) ? hist[j] : 99, exp_seq[j]);

    // Backpressure, then full_dn toggling during FWD.
    do_reset();
    pkt_in[2*DW +: DW] = 32'hBEEF_0002;
    full_dn = 1'b1;
    req_in = 4'b0100;
    repeat (3) tick();
    chk("bp_req_dn", req_dn, 0);
    chk("bp_full_out", full_out, 4'b1111);
    full_dn = 1'b0;
    tick();
    chk("bp_req_rise", req_dn, 1);
    chk("bp_owner", owner, 2);
    chk("bp_pkt_dn", pkt_dn, 32'hBEEF_0002);
    full_dn = 1'b1;
    tick();
    chk("bp_fwd_full", req_dn, 1);
    chk("bp_fwd_full_out", full_out, 4'b1111);
    full_dn = 1'b0;
    gnt_dn = 1'b1;
    tick();
    gnt_dn = 1'b0;
    chk("bp_gnt_out", gnt_out, 4'b0100);

    // Exclusion while owner 1 is busy; late request 3 waits for RELEASE.
    do_reset();
    pkt_in[1*DW +: DW] = 32'h1111_0001;
    pkt_in[3*DW +: DW] = 32'h3333_0003;
    req_in = 4'b0010;
    tick();
    chk("ex_owner1", owner, 1);
    chk("ex_full_out", full_out, 4'b1101);
    req_in[3] = 1'b1;
    repeat (3) tick();
    chk("ex_hold_req", req_dn, 1);
    chk("ex_hold_owner", owner, 1);
    gnt_dn = 1'b1;
    tick();
    gnt_dn = 1'b0;
    chk("ex_gnt_out", gnt_out, 4'b0010);
    chk("ex_req_drop", req_dn, 0);
    tick();
    chk("ex_not_served", req_dn, 0);
    chk("ex_idle", busy, 0);
    gnt_dn = 1'b1;
    tick();
    chk("ex_late_req", req_dn, 1);
    chk("ex_owner3", owner, 3);
    gnt_dn = 1'b0;
    chk("ex_idle_gnt_ignored", gnt_out, 0);

    // Reset in the middle of a forward to injector 2.
    do_reset();
    auto_router = 1;
    rdelay = 1;
    req_in = 4'b0001;
    for (int n = 0; n < 10 && hist.size() < 1; n++) tick();
    auto_router = 0;
    gnt_dn = 1'b0;
    tick();
    req_in = 4'b0101;
    tick();
    chk("rs_pre_owner", owner, 2);
    chk("rs_pre_req", req_dn, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rs_req_dn", req_dn, 0);
    chk("rs_gnt_out", gnt_out, 0);
    chk("rs_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rs_first_owner", owner, 0);
    chk("rs_first_req", req_dn, 1);

`ifdef ARB_GRANT_CNT_EN
    do_reset();
    auto_router = 1;
    rdelay = 1;
    rearm = 1;
    req_in = 4'b0100;
    for (int n = 0; n < 60 && hist.size() < 3; n++) tick();
    rearm = 0;
    wait_idle();
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("cnt_slice%0d", i), grant_cnt[i*GNT_CNT_W +: GNT_CNT_W], (i == 2) ? 3 : 0);
`endif

    do_reset();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
